bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Owns the data port of the 4-byte-lane word BRAM and shares it between the CPU load/store unit and the program loader (UART boot/debug writer).
//  Converts CPU byte-addressed LB/LH/LW/SB/SH/SW requests into word address + byte-select, aligns store data, and sign/zero-extends load data.
//  Never asserts bram_ren and bram_wen together; the BRAM silently drops writes in that case.
// PARAMETERS
//  ADDR_W     11  BRAM word-address width (byte address is ADDR_W+2)
//  MAX_BURST  8   max consecutive loader grants while the CPU is waiting (1..255)
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  reset         in   1        asynchronous, active-low reset
//  cpu_req       in   1        CPU access request, held until cpu_gnt
//  cpu_we        in   1        1=store, 0=load
//  cpu_size      in   2        00=byte 01=half 10=word (11 treated as word)
//  cpu_unsigned  in   1        loads: 1=zero-extend, 0=sign-extend
//  cpu_addr      in   ADDR_W+2 byte address
//  cpu_wdata     in   32       store data, LSB-justified
//  cpu_gnt       out  1        request accepted this cycle (comb)
//  cpu_rvalid    out  1        load data / error response valid (reg)
//  cpu_rdata     out  32       extended load data; 0 on error
//  cpu_err       out  1        misaligned access response, with cpu_rvalid
//  ldr_req       in   1        loader full-word write request
//  ldr_addr      in   ADDR_W   loader word address
//  ldr_wdata     in   32       loader write data
//  ldr_gnt       out  1        loader write accepted this cycle (comb)
//  bram_ren      out  1        BRAM data-port read
//  bram_wen      out  1        BRAM data-port write
//  bram_bsel     out  4        byte lanes to write
//  bram_addr     out  ADDR_W   BRAM data-port word address
//  bram_wdata    out  32       lane-aligned write data
//  bram_rdata    in   32       BRAM data output, one cycle after bram_ren
// BEHAVIOUR
//  Reset: owner state=CPU, burst_cnt=0, rd_pend=0; cpu_rvalid=0, cpu_err=0, cpu_rdata=0; all comb outputs 0 when idle.
//  Owner FSM: CPU -> LDR when ldr_req & !cpu_req; or when ldr_req and the last grant was CPU (alternate).
//   LDR -> CPU when !ldr_req, or when cpu_req and burst_cnt==MAX_BURST.
//  burst_cnt: +1 per ldr_gnt while cpu_req=1; cleared on every cpu_gnt and whenever cpu_req=0; saturates at MAX_BURST.
//  Exactly one of cpu_gnt/ldr_gnt per cycle, at most. With a single requester, that requester is granted every cycle.
//  Loader grant: bram_wen=1, bram_bsel=4'b1111, bram_addr=ldr_addr, bram_wdata=ldr_wdata.
//  CPU grant, aligned: bram_addr=cpu_addr[ADDR_W+1:2], off=cpu_addr[1:0].
//   store: bram_wen=1; bsel = byte 0001<<off, half 0011<<off, word 1111; wdata = byte replicated x4, half replicated x2, word as-is.
//   load: bram_ren=1, bsel=0. Latch off/size/unsigned; rd_pend=1.
//   Next cycle: cpu_rvalid=1; cpu_rdata = lane extracted from bram_rdata at off, then extended.
//  Misaligned (half with off[0]=1; word with off!=0): granted, no BRAM access; next cycle cpu_rvalid=1, cpu_err=1, cpu_rdata=0. Applies to loads and stores.
//  Aligned stores produce no rvalid.
//  Pipelining: back-to-back loads supported, one per cycle; rvalid N+1 for a grant in cycle N.
//   A loader write may follow a CPU load the next cycle; the pending response is still delivered.
//  Reset mid-read: pending response is discarded, with no rvalid after reset release.
// STRUCTURE
//  Shared package: SIZE_B/SIZE_H/SIZE_W encodings, OWN_CPU/OWN_LDR state encodings.
//  One sub-module: bram_load_align (comb: rdata, off, size, unsigned -> extended 32-bit word), reused by the instruction-side debug path.
// TESTING
//  LB 0x005 (unsigned=0), BRAM word@1=0x11228344 -> bram_ren, addr=1; next cycle rvalid, rdata=0xFFFFFF83.
//  SH 0x00A, wdata=0xBEEF -> bram_wen, addr=2, bsel=1100, wdata=0xBEEFBEEF; no rvalid.
//  LW 0x006 -> no bram_ren/wen; next cycle rvalid=1, err=1, rdata=0.
//  ldr_req and cpu_req held 20 cycles, MAX_BURST=8, owner=LDR -> at most 8 ldr_gnt between cpu_gnts; never both gnts.
//  LW 0x000, 0x004, 0x008 back-to-back -> 3 consecutive rvalids, correct words; ren&wen never both 1 (assertion).
//  Drop reset in the cycle after a load grant -> cpu_rvalid=0 during and after reset; FSM=CPU.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// Shared encodings for the BRAM data-port arbiter.
// Access sizes, owner states and the alignment rule.
package bram_port_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  // size 2'b11 behaves as a word
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      size == SIZE_B: m = 1'b0;
      size == SIZE_H: m = off[0];
      default:        m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// CPU, loader and BRAM data-port signal bundle.
// slave = arbiter side, master = requesters plus BRAM.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic              cpu_unsigned;
  logic [ADDR_W+1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;
  logic              cpu_err;
  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic [31:0]       ldr_wdata;
  logic              ldr_gnt;
  logic              bram_ren;
  logic              bram_wen;
  logic [3:0]        bram_bsel;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_wdata;
  logic [31:0]       bram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_size,
    input  cpu_unsigned, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid,
    output cpu_rdata, cpu_err,
    input  ldr_req, ldr_addr, ldr_wdata,
    output ldr_gnt,
    output bram_ren, bram_wen, bram_bsel,
    output bram_addr, bram_wdata,
    input  bram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_size,
    output cpu_unsigned, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid,
    input  cpu_rdata, cpu_err,
    output ldr_req, ldr_addr, ldr_wdata,
    input  ldr_gnt,
    input  bram_ren, bram_wen, bram_bsel,
    input  bram_addr, bram_wdata,
    output bram_rdata
  );

endinterface

// File: rtl/bram_load_align.sv
// Extracts a byte/half/word lane from a BRAM word and extends it.
// Also used by the instruction-side debug read path.
module bram_load_align
  import bram_port_arbiter_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    data   = rdata;
    unique case (size)
      SIZE_B: data = uns ? {24'b0, byte_v}
                         : {{24{byte_v[7]}}, byte_v};
      SIZE_H: data = uns ? {16'b0, half_v}
                         : {{16{half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares the word BRAM data port between the CPU LSU and the loader.
// Handles byte-lane steering, load extension and misalignment errors.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MAX_BURST = 8
) (
  input logic                clk,
  input logic                reset,
  bram_port_arbiter_if.slave bus
);

  localparam logic [7:0] BMAX = 8'(MAX_BURST);

  owner_t     owner;
  owner_t     eff;
  logic [7:0] burst_cnt;
  logic       ldr_win;
  logic       cpu_gnt;
  logic [1:0] off;
  logic       mis;
  logic       cpu_ok;
  logic       rv_q;
  logic       err_q;
  logic [1:0] off_q;
  logic [1:0] size_q;
  logic       uns_q;
  logic [31:0] ld_data;

  assign off = bus.cpu_addr[1:0];
  assign mis = misaligned(bus.cpu_size, off);

  // Loader loses ownership once its burst budget is spent
  always_comb begin
    eff = owner;
    if (owner == OWN_LDR &&
        (!bus.ldr_req ||
         (bus.cpu_req && burst_cnt == BMAX)))
      eff = OWN_CPU;
  end

  assign ldr_win = bus.ldr_req &&
                   (!bus.cpu_req || eff == OWN_LDR);
  assign cpu_gnt = bus.cpu_req && !ldr_win;
  assign cpu_ok  = cpu_gnt && !mis;

  assign bus.cpu_gnt = cpu_gnt;
  assign bus.ldr_gnt = ldr_win;

  always_comb begin
    bus.bram_ren   = 1'b0;
    bus.bram_wen   = 1'b0;
    bus.bram_bsel  = 4'b0000;
    bus.bram_addr  = '0;
    bus.bram_wdata = 32'b0;
    unique case (1'b1)
      ldr_win: begin
        bus.bram_wen   = 1'b1;
        bus.bram_bsel  = 4'b1111;
        bus.bram_addr  = bus.ldr_addr;
        bus.bram_wdata = bus.ldr_wdata;
      end
      cpu_ok && bus.cpu_we: begin
        bus.bram_wen  = 1'b1;
        bus.bram_addr = bus.cpu_addr[ADDR_W+1:2];
        unique case (bus.cpu_size)
          SIZE_B: begin
            bus.bram_bsel  = 4'b0001 << off;
            bus.bram_wdata = {4{bus.cpu_wdata[7:0]}};
          end
          SIZE_H: begin
            bus.bram_bsel  = 4'b0011 << off;
            bus.bram_wdata = {2{bus.cpu_wdata[15:0]}};
          end
          default: begin
            bus.bram_bsel  = 4'b1111;
            bus.bram_wdata = bus.cpu_wdata;
          end
        endcase
      end
      cpu_ok && !bus.cpu_we: begin
        bus.bram_ren  = 1'b1;
        bus.bram_addr = bus.cpu_addr[ADDR_W+1:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_CPU;
      burst_cnt <= 8'd0;
      rv_q      <= 1'b0;
      err_q     <= 1'b0;
      off_q     <= 2'b00;
      size_q    <= SIZE_B;
      uns_q     <= 1'b0;
    end else begin
      // A CPU grant with the loader waiting hands the port over
      unique case (eff)
        OWN_CPU: owner <= bus.ldr_req ? OWN_LDR : OWN_CPU;
        OWN_LDR: owner <= OWN_LDR;
        default: owner <= OWN_CPU;
      endcase
      if (cpu_gnt || !bus.cpu_req)
        burst_cnt <= 8'd0;
      else if (ldr_win && burst_cnt != BMAX)
        burst_cnt <= burst_cnt + 8'd1;
      rv_q  <= cpu_gnt && (!bus.cpu_we || mis);
      err_q <= cpu_gnt && mis;
      if (cpu_gnt) begin
        off_q  <= off;
        size_q <= bus.cpu_size;
        uns_q  <= bus.cpu_unsigned;
      end
    end
  end

  bram_load_align u_align (
    .rdata (bus.bram_rdata),
    .off   (off_q),
    .size  (size_q),
    .uns   (uns_q),
    .data  (ld_data)
  );

  assign bus.cpu_rvalid = rv_q;
  assign bus.cpu_err    = err_q;
  assign bus.cpu_rdata  = (rv_q && !err_q) ? ld_data : 32'b0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small BRAM model.
// Expected values are hand-computed constants.
module tb_bram_port_arbiter;
  import bram_port_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] mem [0:15];

  bram_port_arbiter_if #(.ADDR_W(11)) bif ();

  bram_port_arbiter #(
    .ADDR_W(11),
    .MAX_BURST(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'b0;
      mem[0] <= 32'h0000_0010;
      mem[1] <= 32'h1122_8344;
      mem[2] <= 32'hCAFE_F00D;
      bif.bram_rdata <= 32'b0;
    end else begin
      if (bif.bram_ren)
        bif.bram_rdata <= mem[bif.bram_addr[3:0]];
      if (bif.bram_wen)
        for (int l = 0; l < 4; l++)
          if (bif.bram_bsel[l])
            mem[bif.bram_addr[3:0]][l*8 +: 8]
              <= bif.bram_wdata[l*8 +: 8];
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      checks++;
      assert (!(bif.bram_ren && bif.bram_wen)) else begin
        errors++;
        $error("FAIL ren_wen: ren=%b wen=%b exp not both",
               bif.bram_ren, bif.bram_wen);
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    bif.cpu_req      = 1'b0;
    bif.cpu_we       = 1'b0;
    bif.cpu_size     = 2'b00;
    bif.cpu_unsigned = 1'b0;
    bif.cpu_addr     = '0;
    bif.cpu_wdata    = 32'b0;
    bif.ldr_req      = 1'b0;
    bif.ldr_addr     = '0;
    bif.ldr_wdata    = 32'b0;
  endtask

  task automatic cpu(input logic we, input logic [1:0] sz,
                     input logic u, input logic [12:0] a,
                     input logic [31:0] wd);
    bif.cpu_req      = 1'b1;
    bif.cpu_we       = we;
    bif.cpu_size     = sz;
    bif.cpu_unsigned = u;
    bif.cpu_addr     = a;
    bif.cpu_wdata    = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input string tag,
                      input logic [1:0] sz, input logic u,
                      input logic [12:0] a,
                      input logic [31:0] exp);
    cpu(1'b0, sz, u, a, 32'b0);
    #1;
    chk({tag, "_ren"}, 32'(bif.bram_ren), 32'd1);
    chk({tag, "_addr"}, 32'(bif.bram_addr), 32'(a[12:2]));
    tick();
    idle();
    chk({tag, "_rv"}, 32'(bif.cpu_rvalid), 32'd1);
    chk({tag, "_data"}, bif.cpu_rdata, exp);
  endtask

  int run;
  int max_run;
  int cpu_cnt;
  int both_cnt;

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_rvalid", 32'(bif.cpu_rvalid), 32'd0);
    chk("rst_err", 32'(bif.cpu_err), 32'd0);
    chk("rst_rdata", bif.cpu_rdata, 32'd0);
    chk("rst_gnt", {30'b0, bif.cpu_gnt, bif.ldr_gnt}, 32'd0);
    chk("rst_owner", 32'(dut.owner), 32'(OWN_CPU));
    reset = 1'b1;
    tick();

    load("lb5", SIZE_B, 1'b0, 13'h005, 32'hFFFF_FF83);
    load("lbu5", SIZE_B, 1'b1, 13'h005, 32'h0000_0083);
    load("lh6", SIZE_H, 1'b0, 13'h006, 32'h0000_1122);
    load("lh4", SIZE_H, 1'b0, 13'h004, 32'hFFFF_8344);

    cpu(1'b1, SIZE_H, 1'b0, 13'h00A, 32'h0000_BEEF);
    #1;
    chk("sh_gnt", 32'(bif.cpu_gnt), 32'd1);
    chk("sh_wen", 32'(bif.bram_wen), 32'd1);
    chk("sh_addr", 32'(bif.bram_addr), 32'd2);
    chk("sh_bsel", 32'(bif.bram_bsel), 32'hC);
    chk("sh_wdata", bif.bram_wdata, 32'hBEEF_BEEF);
    tick();
    idle();
    chk("sh_norv", 32'(bif.cpu_rvalid), 32'd0);

    cpu(1'b1, SIZE_B, 1'b0, 13'h003, 32'h0000_005A);
    #1;
    chk("sb_bsel", 32'(bif.bram_bsel), 32'h8);
    chk("sb_wdata", bif.bram_wdata, 32'h5A5A_5A5A);
    tick();
    idle();

    cpu(1'b0, SIZE_W, 1'b0, 13'h006, 32'b0);
    #1;
    chk("mis_gnt", 32'(bif.cpu_gnt), 32'd1);
    chk("mis_acc", {30'b0, bif.bram_ren, bif.bram_wen}, 32'd0);
    tick();
    idle();
    chk("mis_rv", 32'(bif.cpu_rvalid), 32'd1);
    chk("mis_err", 32'(bif.cpu_err), 32'd1);
    chk("mis_data", bif.cpu_rdata, 32'd0);
    tick();
    chk("mis_rv_off", 32'(bif.cpu_rvalid), 32'd0);

    cpu(1'b0, SIZE_W, 1'b0, 13'h000, 32'b0);
    tick();
    chk("b2b0_rv", 32'(bif.cpu_rvalid), 32'd1);
    chk("b2b0", bif.cpu_rdata, 32'h5A00_0010);
    cpu(1'b0, SIZE_W, 1'b0, 13'h004, 32'b0);
    tick();
    chk("b2b1_rv", 32'(bif.cpu_rvalid), 32'd1);
    chk("b2b1", bif.cpu_rdata, 32'h1122_8344);
    cpu(1'b0, SIZE_W, 1'b0, 13'h008, 32'b0);
    tick();
    idle();
    chk("b2b2_rv", 32'(bif.cpu_rvalid), 32'd1);
    chk("b2b2", bif.cpu_rdata, 32'hBEEF_F00D);
    tick();
    chk("b2b_end", 32'(bif.cpu_rvalid), 32'd0);

    cpu(1'b0, SIZE_W, 1'b0, 13'h004, 32'b0);
    tick();
    idle();
    bif.ldr_req   = 1'b1;
    bif.ldr_addr  = 11'd3;
    bif.ldr_wdata = 32'h1234_5678;
    #1;
    chk("ld_ldr_gnt", 32'(bif.ldr_gnt), 32'd1);
    chk("ld_ldr_bsel", 32'(bif.bram_bsel), 32'hF);
    chk("ld_ldr_addr", 32'(bif.bram_addr), 32'd3);
    chk("ld_ldr_wd", bif.bram_wdata, 32'h1234_5678);
    chk("ld_pend_rv", 32'(bif.cpu_rvalid), 32'd1);
    chk("ld_pend", bif.cpu_rdata, 32'h1122_8344);
    tick();
    chk("ldr_mem", mem[3], 32'h1234_5678);

    run = 0;
    max_run = 0;
    cpu_cnt = 0;
    both_cnt = 0;
    bif.ldr_addr = 11'd5;
    cpu(1'b0, SIZE_W, 1'b0, 13'h000, 32'b0);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bif.cpu_gnt && bif.ldr_gnt) both_cnt++;
      if (bif.cpu_gnt) begin
        cpu_cnt++;
        run = 0;
      end
      if (bif.ldr_gnt) begin
        run++;
        if (run > max_run) max_run = run;
      end
      tick();
    end
    idle();
    chk("burst_max", 32'(max_run), 32'd8);
    chk("burst_cpu", 32'(cpu_cnt), 32'd2);
    chk("burst_both", 32'(both_cnt), 32'd0);
    tick();

    cpu(1'b0, SIZE_W, 1'b0, 13'h004, 32'b0);
    #1;
    chk("rr_gnt", 32'(bif.cpu_gnt), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("rr_rv_in", 32'(bif.cpu_rvalid), 32'd0);
    chk("rr_owner", 32'(dut.owner), 32'(OWN_CPU));
    tick();
    reset = 1'b1;
    tick();
    chk("rr_rv_after", 32'(bif.cpu_rvalid), 32'd0);
    tick();
    chk("rr_rv_after2", 32'(bif.cpu_rvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
